func_sweep_ctrl: RTL and testbench
==================================

# func_sweep_ctrl

Synthesizable sweep controller that sits around the 4-input function implementations (`func_df`, `func_1mux`, `func_2mux`). It drives their shared input vector {A,B,C,D} through every code from 0000 to 1111, holding each vector for a fixed number of cycles. At the end of each hold window it samples the three outputs and checks them against each other. It reports mismatch count, first failing vector and a pass/done status, so the exhaustive check runs on the board as well as in simulation.

## Interface

Parameters:
- `N_IN`, default 4, width of the driven input vector; the sweep covers 2^N_IN codes.
- `HOLD`, default 10, clock cycles each vector is held (legal range ≥ 1).

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: reset is synchronous and active-high.
- `start` in 1: begins a sweep when sampled high in IDLE or DONE; ignored while busy.
- `abcd` out N_IN: vector driven to the implementations; MSB = A, LSB = D.
- `y_df` in 1: output of the dataflow implementation.
- `y_1mux` in 1: output of the one-mux implementation.
- `y_2mux` in 1: output of the two-mux implementation.
- `busy` out 1: high while the sweep is in progress.
- `done` out 1: high from sweep completion until the next accepted start or reset.
- `pass` out 1: valid while `done` is high; 1 if no mismatch occurred.
- `err_cnt` out N_IN+1: number of mismatching vectors, saturating at 2^N_IN.
- `err_mask` out 2: sticky disagreement flags. Bit0 is set when `y_1mux` ≠ `y_df`; bit1 is set when `y_2mux` ≠ `y_df`.
- `first_err_valid` out 1: set on the first mismatch of a sweep.
- `first_err_vec` out N_IN: `abcd` value at the first mismatch; frozen once `first_err_valid` is set.

## Operation

- FSM states:
  - IDLE → DRIVE on `start`.
  - DRIVE → DRIVE on vector advance.
  - DRIVE → DONE after the last vector is checked.
  - DONE → DRIVE on `start`.
- Start acceptance, in IDLE or DONE: clear `abcd`, `err_cnt`, `err_mask`, `first_err_*`, `done`, `pass` and the hold counter; set `busy`.
- DRIVE: the hold counter counts 0..HOLD-1 and `abcd` is stable throughout.
- Check cycle = the DRIVE cycle with hold counter == HOLD-1. The implementations are combinational, so outputs are compared in that same cycle.
- Mismatch = not all three `y` inputs equal. On a mismatch:
  - `err_cnt` increments.
  - `err_mask` bits OR in.
  - If `first_err_valid` = 0, then `first_err_vec` ← `abcd` and `first_err_valid` ← 1.
- After the check cycle:
  - If `abcd` is all-ones: go to DONE, `busy` ← 0, `done` ← 1, `pass` ← (next `err_cnt` == 0).
  - Otherwise: `abcd` ← `abcd` + 1 and the hold counter ← 0.
- `abcd` never wraps to 0 inside a sweep. Terminal detection is all-ones, not overflow.
- `abcd` keeps its last value (all-ones) in DONE.
- `start` high during DRIVE has no effect.
- `start` high in DONE restarts the sweep immediately.

## Timing

- Reset values: `abcd` = 0, `busy` = 0, `done` = 0, `pass` = 0, `err_cnt` = 0, `err_mask` = 0, `first_err_valid` = 0, `first_err_vec` = 0, FSM = IDLE, hold counter = 0.
- Reset has priority over `start` and takes effect at the next edge from any state, including mid-sweep. There is no partial-result retention.
- Start at edge k: `busy` = 1 and `abcd` = 0 from edge k.
- Vector n is driven during edges k + n·HOLD through k + (n+1)·HOLD − 1.
- `done` rises at edge k + 2^N_IN·HOLD. With the defaults this is 160 cycles.
- HOLD = 1: each vector is driven and checked in the same single cycle; no idle cycles between vectors.
- Counters and flags are registered outputs. A mismatch in the check cycle becomes visible one edge later.

## Structure

- Package `func_sweep_pkg`: FSM state enum (IDLE, DRIVE, DONE) and a width helper constant for `err_cnt` (N_IN+1).
- One sub-module, `hold_timer`:
  - Parameter HOLD.
  - Inputs `clr` and `en`.
  - Output `last` (count == HOLD-1).
  - Counter width = $clog2(HOLD) with a minimum of 1.
- The FSM, vector register and error bookkeeping live in `func_sweep_ctrl`.

## Test plan

Each scenario drives behavioural stub functions into the `y` inputs.

- Three identical stubs, HOLD = 10, pulse `start` → `abcd` steps 0..15, each for 10 cycles; `done` = 1 after 160 cycles; `pass` = 1, `err_cnt` = 0, `err_mask` = 00.
- `y_2mux` stub inverted only for `abcd` = 0101 and 1100 → `err_cnt` = 2, `err_mask` = 10, `first_err_vec` = 0101, `pass` = 0.
- HOLD = 1 with all stubs mismatching everywhere → `done` after 16 cycles; `err_cnt` = 16 (no overflow), `first_err_vec` = 0000.
- Assert `start` again at cycle 50 mid-sweep → ignored: `abcd` sequence unbroken, completion still at cycle 160. Then `start` in DONE → all results cleared, `abcd` = 0 on the next edge.
- Assert `rst` with `abcd` = 0111 mid-sweep → next edge all outputs at reset values, FSM IDLE. A subsequent `start` runs a full 160-cycle sweep.
- `rst` and `start` high in the same cycle → reset wins; `busy` stays 0.

Source files
------------

// File: rtl/func_sweep_pkg.sv
// Shared types and width helpers for the function sweep controller.
package func_sweep_pkg;

    // Sweep controller states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } sweep_state_t;

    localparam int N_IN_DEFAULT = 4;
    localparam int HOLD_DEFAULT = 10;

    // err_cnt must hold 2^N_IN, which needs one bit more than the vector.
    localparam int ERR_CNT_W_DEFAULT = N_IN_DEFAULT + 1;

    function automatic int err_cnt_width(input int n_in);
        return n_in + 1;
    endfunction

    // Hold counter width; a single-cycle hold still gets one bit.
    function automatic int hold_cnt_width(input int hold);
        return (hold > 1) ? $clog2(hold) : 1;
    endfunction

endpackage

// File: rtl/func_sweep_ctrl_hold_timer.sv
// Hold-window timer: counts 0..HOLD-1 while enabled and flags the last cycle.
module hold_timer
    import func_sweep_pkg::*;
#(
    parameter int HOLD = HOLD_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic last
);

    localparam int CW = hold_cnt_width(HOLD);
    localparam logic [CW-1:0] LAST_VAL = CW'(HOLD - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign last = (cnt_q == LAST_VAL);

    // Next count: clear wins, otherwise step and wrap after the last cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = last ? '0 : cnt_q + 1'b1;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/func_sweep_ctrl.sv
// Exhaustive sweep of a 4-input function over three implementations,
// comparing their outputs at the end of each hold window.
//
// start handshake: start is a level request sampled on every rising edge;
// it is accepted only in IDLE or DONE (accept == start && !busy), and any
// start seen while busy is dropped with no effect. There is no ready output:
// busy low means the next start will be accepted.
module func_sweep_ctrl
    import func_sweep_pkg::*;
#(
    parameter int N_IN = N_IN_DEFAULT,
    parameter int HOLD = HOLD_DEFAULT
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    output logic [N_IN-1:0]                  abcd,
    input  logic                             y_df,
    input  logic                             y_1mux,
    input  logic                             y_2mux,
    output logic                             busy,
    output logic                             done,
    output logic                             pass,
    output logic [err_cnt_width(N_IN)-1:0]   err_cnt,
    output logic [1:0]                       err_mask,
    output logic                             first_err_valid,
    output logic [N_IN-1:0]                  first_err_vec,
    output sweep_state_t                     state_dbg
);

    localparam int ECW = err_cnt_width(N_IN);
    localparam logic [ECW-1:0] ERR_MAX = ECW'(1 << N_IN);

    sweep_state_t      state_q, state_d;
    logic [N_IN-1:0]   abcd_q, abcd_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [ECW-1:0]    err_cnt_q, err_cnt_d;
    logic [1:0]        err_mask_q, err_mask_d;
    logic              fev_q, fev_d;
    logic [N_IN-1:0]   fvec_q, fvec_d;

    logic              timer_clr;
    logic              timer_en;
    logic              timer_last;

    logic              diff_1mux;
    logic              diff_2mux;
    logic              mismatch;
    logic              last_vec;

    hold_timer #(
        .HOLD (HOLD)
    ) u_hold_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (timer_clr),
        .en   (timer_en),
        .last (timer_last)
    );

    // The implementations are combinational, so they are compared live.
    assign diff_1mux = (y_1mux != y_df);
    assign diff_2mux = (y_2mux != y_df);
    assign mismatch  = diff_1mux | diff_2mux;
    assign last_vec  = &abcd_q;

    // Next-state and bookkeeping: defaults hold every register.
    always_comb begin
        state_d    = state_q;
        abcd_d     = abcd_q;
        busy_d     = busy_q;
        done_d     = done_q;
        pass_d     = pass_q;
        err_cnt_d  = err_cnt_q;
        err_mask_d = err_mask_q;
        fev_d      = fev_q;
        fvec_d     = fvec_q;
        timer_clr  = 1'b0;
        timer_en   = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d    = ST_DRIVE;
                    abcd_d     = '0;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    pass_d     = 1'b0;
                    err_cnt_d  = '0;
                    err_mask_d = '0;
                    fev_d      = 1'b0;
                    fvec_d     = '0;
                    timer_clr  = 1'b1;
                end
            end

            ST_DRIVE: begin
                timer_en = 1'b1;
                if (timer_last) begin
                    // Check cycle for the current vector.
                    if (mismatch) begin
                        if (err_cnt_q != ERR_MAX) begin
                            err_cnt_d = err_cnt_q + 1'b1;
                        end
                        err_mask_d = err_mask_q | {diff_2mux, diff_1mux};
                        if (!fev_q) begin
                            fev_d  = 1'b1;
                            fvec_d = abcd_q;
                        end
                    end
                    // Terminal detection is on all-ones, never on wrap.
                    if (last_vec) begin
                        state_d   = ST_DONE;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                        pass_d    = (err_cnt_d == '0);
                        timer_clr = 1'b1;
                    end else begin
                        abcd_d    = abcd_q + 1'b1;
                        timer_clr = 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and result registers; reset beats start from any state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            abcd_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_cnt_q  <= '0;
            err_mask_q <= '0;
            fev_q      <= 1'b0;
            fvec_q     <= '0;
        end else begin
            state_q    <= state_d;
            abcd_q     <= abcd_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            err_cnt_q  <= err_cnt_d;
            err_mask_q <= err_mask_d;
            fev_q      <= fev_d;
            fvec_q     <= fvec_d;
        end
    end

    assign abcd            = abcd_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign err_cnt         = err_cnt_q;
    assign err_mask        = err_mask_q;
    assign first_err_valid = fev_q;
    assign first_err_vec   = fvec_q;
    assign state_dbg       = state_q;

endmodule

// File: tb/tb_func_sweep_ctrl.sv
// Bench for func_sweep_ctrl: one instance with HOLD=10 (a) and one with
// HOLD=1 (b), each fed by truth-table stubs with per-vector fault masks.
module tb_func_sweep_ctrl;
    import func_sweep_pkg::*;

    typedef struct packed {
        logic [3:0] abcd;
        logic       busy;
        logic       done;
        logic       pass;
        logic [4:0] err_cnt;
        logic [1:0] mask;
        logic       fev;
        logic [3:0] fvec;
        logic [1:0] st;
    } snap_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, start_a, rst_b, start_b;

    // ---------------- DUT a (HOLD=10) ----------------
    logic [3:0]   abcd_a, fvec_a;
    logic         busy_a, done_a, pass_a, fev_a;
    logic [4:0]   cnt_a;
    logic [1:0]   mask_a;
    sweep_state_t st_a;
    logic [15:0]  tt_a, inv1_a, inv2_a;
    logic         y_df_a, y_1mux_a, y_2mux_a;

    assign y_df_a   = tt_a[abcd_a];
    assign y_1mux_a = tt_a[abcd_a] ^ inv1_a[abcd_a];
    assign y_2mux_a = tt_a[abcd_a] ^ inv2_a[abcd_a];

    func_sweep_ctrl #(.N_IN(4), .HOLD(10)) dut_a (
        .clk(clk), .rst(rst_a), .start(start_a), .abcd(abcd_a),
        .y_df(y_df_a), .y_1mux(y_1mux_a), .y_2mux(y_2mux_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err_cnt(cnt_a),
        .err_mask(mask_a), .first_err_valid(fev_a), .first_err_vec(fvec_a),
        .state_dbg(st_a)
    );

    // ---------------- DUT b (HOLD=1) ----------------
    logic [3:0]   abcd_b, fvec_b;
    logic         busy_b, done_b, pass_b, fev_b;
    logic [4:0]   cnt_b;
    logic [1:0]   mask_b;
    sweep_state_t st_b;
    logic [15:0]  tt_b, inv1_b, inv2_b;
    logic         y_df_b, y_1mux_b, y_2mux_b;

    assign y_df_b   = tt_b[abcd_b];
    assign y_1mux_b = tt_b[abcd_b] ^ inv1_b[abcd_b];
    assign y_2mux_b = tt_b[abcd_b] ^ inv2_b[abcd_b];

    func_sweep_ctrl #(.N_IN(4), .HOLD(1)) dut_b (
        .clk(clk), .rst(rst_b), .start(start_b), .abcd(abcd_b),
        .y_df(y_df_b), .y_1mux(y_1mux_b), .y_2mux(y_2mux_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_cnt(cnt_b),
        .err_mask(mask_b), .first_err_valid(fev_b), .first_err_vec(fvec_b),
        .state_dbg(st_b)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- access helpers ----------------
    function automatic snap_t snap(input int which);
        snap_t s;
        if (which == 0) begin
            s = '{abcd_a, busy_a, done_a, pass_a, cnt_a, mask_a, fev_a, fvec_a, st_a};
        end else begin
            s = '{abcd_b, busy_b, done_b, pass_b, cnt_b, mask_b, fev_b, fvec_b, st_b};
        end
        return s;
    endfunction

    task automatic set_start(input int which, input logic v);
        if (which == 0) start_a = v; else start_b = v;
    endtask

    task automatic set_rst(input int which, input logic v);
        if (which == 0) rst_a = v; else rst_b = v;
    endtask

    task automatic set_stubs(input int which, input logic [15:0] tt,
                             input logic [15:0] i1, input logic [15:0] i2);
        if (which == 0) begin
            tt_a = tt; inv1_a = i1; inv2_a = i2;
        end else begin
            tt_b = tt; inv1_b = i1; inv2_b = i2;
        end
    endtask

    // ---------------- reference model ----------------
    // Results expected after the first nvec vectors of a sweep have been
    // checked: a vector is bad when any implementation disagrees.
    function automatic snap_t model(input int which, input int nvec);
        snap_t e;
        logic [15:0] i1, i2;
        i1 = (which == 0) ? inv1_a : inv1_b;
        i2 = (which == 0) ? inv2_a : inv2_b;
        e = '0;
        for (int v = 0; v < nvec; v++) begin
            if (i1[v] || i2[v]) begin
                e.err_cnt = e.err_cnt + 5'd1;
                e.mask    = e.mask | {i2[v], i1[v]};
                if (!e.fev) begin
                    e.fev  = 1'b1;
                    e.fvec = 4'(v);
                end
            end
        end
        return e;
    endfunction

    // Full sweep with per-cycle checking. inj_at: cycle at which a stray
    // start is raised mid-sweep; abort_at: cycle at which to return early.
    task automatic run_sweep(input int which, input int inj_at, input int abort_at);
        int    hold;
        int    total;
        snap_t s;
        snap_t e;
        hold  = (which == 0) ? 10 : 1;
        total = 16 * hold;
        set_start(which, 1'b1);
        @(posedge clk); #1;
        set_start(which, 1'b0);
        for (int c = 0; c < total; c++) begin
            if (c == abort_at) return;
            s = snap(which);
            e = model(which, c / hold);
            e.abcd = 4'(c / hold);
            e.busy = 1'b1;
            e.st   = ST_DRIVE;
            checks++;
            if (s !== e) begin
                errors++;
                $display("FAIL sweep%0d cyc=%0d got=%h exp=%h", which, c, s, e);
            end
            if (c == inj_at) set_start(which, 1'b1);
            @(posedge clk); #1;
            set_start(which, 1'b0);
        end
        e = model(which, 16);
        e.abcd = 4'hF;
        e.done = 1'b1;
        e.pass = (e.err_cnt == 5'd0);
        e.st   = ST_DONE;
        for (int k = 0; k < 2; k++) begin
            s = snap(which);
            checks++;
            if (s !== e) begin
                errors++;
                $display("FAIL sweep%0d_done%0d got=%h exp=%h", which, k, s, e);
            end
            @(posedge clk); #1;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        snap_t e;
        e = '0;
        e.st = ST_IDLE;
        rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_a = 1'b0; rst_b = 1'b0;
        for (int w = 0; w < 2; w++) begin
            checks++;
            if (snap(w) !== e) begin
                errors++;
                $display("FAIL reset%0d got=%h exp=%h", w, snap(w), e);
            end
        end
    endtask

    task automatic test_clean;
        set_stubs(0, 16'($urandom), 16'h0000, 16'h0000);
        run_sweep(0, -1, -1);
        checks++;
        if (pass_a !== 1'b1 || cnt_a !== 5'd0 || mask_a !== 2'b00) begin
            errors++;
            $display("FAIL clean pass=%b cnt=%0d mask=%b exp 1/0/00", pass_a, cnt_a, mask_a);
        end
    endtask

    task automatic test_two_errors;
        set_stubs(0, 16'($urandom), 16'h0000, 16'h1020);
        run_sweep(0, -1, -1);
        checks++;
        if (cnt_a !== 5'd2 || mask_a !== 2'b10 || fvec_a !== 4'b0101 || pass_a !== 1'b0) begin
            errors++;
            $display("FAIL two_err cnt=%0d mask=%b fvec=%b pass=%b exp 2/10/0101/0",
                     cnt_a, mask_a, fvec_a, pass_a);
        end
    endtask

    task automatic test_hold1;
        set_stubs(1, 16'($urandom), 16'hFFFF, 16'h0000);
        run_sweep(1, -1, -1);
        checks++;
        if (cnt_b !== 5'd16 || fvec_b !== 4'b0000 || fev_b !== 1'b1 || mask_b !== 2'b01) begin
            errors++;
            $display("FAIL hold1 cnt=%0d fvec=%b fev=%b mask=%b exp 16/0000/1/01",
                     cnt_b, fvec_b, fev_b, mask_b);
        end
    endtask

    task automatic test_back_to_back;
        // Stray start at cycle 50 is ignored; then a start in DONE restarts
        // with every result cleared on the accepting edge.
        set_stubs(0, 16'($urandom), 16'h0004, 16'h0200);
        run_sweep(0, 50, -1);
        set_stubs(0, 16'($urandom), 16'h0000, 16'h0000);
        run_sweep(0, -1, -1);
    endtask

    task automatic test_rst_midsweep;
        snap_t e;
        e = '0;
        e.st = ST_IDLE;
        set_stubs(0, 16'($urandom), 16'h0008, 16'h0000);
        run_sweep(0, -1, 75);
        checks++;
        if (abcd_a !== 4'b0111) begin
            errors++;
            $display("FAIL rst_mid_pre abcd=%b exp=0111", abcd_a);
        end
        rst_a = 1'b1;
        @(posedge clk); #1;
        rst_a = 1'b0;
        checks++;
        if (snap(0) !== e) begin
            errors++;
            $display("FAIL rst_mid got=%h exp=%h", snap(0), e);
        end
        run_sweep(0, -1, -1);
    endtask

    task automatic test_rst_start_same;
        snap_t e;
        e = '0;
        e.st = ST_IDLE;
        // DUT b sits in DONE with errors from the previous scenario.
        set_rst(1, 1'b1);
        set_start(1, 1'b1);
        @(posedge clk); #1;
        set_rst(1, 1'b0);
        set_start(1, 1'b0);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (snap(1) !== e) begin
                errors++;
                $display("FAIL rst_start%0d got=%h exp=%h", k, snap(1), e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random;
        for (int it = 0; it < 3; it++) begin
            for (int w = 0; w < 2; w++) begin
                set_stubs(w, 16'($urandom),
                          16'($urandom & $urandom & $urandom),
                          16'($urandom & $urandom & $urandom));
                run_sweep(w, -1, -1);
            end
        end
    endtask

    initial begin
        tt_a = '0; inv1_a = '0; inv2_a = '0;
        tt_b = '0; inv1_b = '0; inv2_b = '0;
        test_reset();
        test_clean();
        test_two_errors();
        test_hold1();
        test_back_to_back();
        test_rst_midsweep();
        test_rst_start_same();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
